uart_tx_framer: RTL and testbench

- Packetising stage directly upstream of the UART controller's transmit side.
- Accepts a payload byte stream from user logic through a valid/ready handshake and buffers one frame.
- Pushes SOF, LEN, payload and CHK bytes into the controller's upload FIFO using its VerifyByte strobe, then pulses SendData.
- Waits for the controller to drain before accepting the next frame.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_frame_buf.sv | 65 ++++++
 rtl/uart_tx_framer.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and byte helpers for the UART transmit framer
//
// Contents:
//   byte_t          8-bit byte type used by the checksum helpers
//   SOF_DEFAULT     default start-of-frame marker (8'h7E)
//   framer_state_t  framer FSM state encoding
//   crc8_step       one byte of CRC-8 (poly 0x07, MSB-first, no reflection)
//   checksum_update one byte of the additive mod-256 running sum
package uart_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t SOF_DEFAULT = 8'h7E;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_PUSH_SOF,
      ST_PUSH_LEN,
      ST_PUSH_DATA,
      ST_PUSH_CHK,
      ST_KICK,
      ST_DRAIN
   } framer_state_t;

   function automatic byte_t crc8_step(input byte_t data, input byte_t crc);
      byte_t c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   function automatic byte_t checksum_update(input byte_t sum, input byte_t data);
      return sum + data;
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload store for one frame with write pointer and read index
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset of the pointers
//   clr_i           empty the buffer (write pointer and read index to 0)
//   wr_en_i         store wr_data_i at the write pointer and advance it
//   wr_data_i       payload byte to store
//   rd_next_i       advance the read index
//   rd_data_o       byte at the read index
//   count_o         number of bytes stored (write pointer)
//   rd_idx_o        current read index
module uart_frame_buf #(
   parameter int unsigned DataBits = 8,
   parameter int unsigned Depth    = 16,
   parameter int unsigned CntW     = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   input  logic                wr_en_i,
   input  logic [DataBits-1:0] wr_data_i,
   input  logic                rd_next_i,
   output logic [DataBits-1:0] rd_data_o,
   output logic [CntW-1:0]     count_o,
   output logic [CntW-1:0]     rd_idx_o
);

   localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [DataBits-1:0] mem_q [Depth];
   logic [CntW-1:0]     wptr_q, wptr_d;
   logic [CntW-1:0]     ridx_q, ridx_d;

   always_comb begin
      wptr_d = wptr_q;
      ridx_d = ridx_q;
      if (clr_i) begin
         wptr_d = '0;
         ridx_d = '0;
      end else begin
         if (wr_en_i)   wptr_d = wptr_q + 1'b1;
         if (rd_next_i) ridx_d = ridx_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         ridx_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         ridx_q <= ridx_d;
      end
   end

   // Payload storage needs no reset: nothing is read before it is written.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !clr_i) mem_q[IdxW'(wptr_q)] <= wr_data_i;
   end

   assign rd_data_o = mem_q[IdxW'(ridx_q)];
   assign count_o   = wptr_q;
   assign rd_idx_o  = ridx_q;

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - collects a payload frame and pushes SOF/LEN/payload/CHK to the UART controller
//
// Build option: define UART_TX_FRAMER_CRC8_EN to make CHK a CRC-8 over LEN and payload;
// otherwise CHK is the two's complement of the byte sum of LEN and payload.
//
// Ports:
//   Clk, Reset                 clock, asynchronous active-low reset
//   InByte/InValid/InLast      payload stream from user logic
//   InReady                    framer can accept a payload byte
//   Abort                      drop the frame being collected
//   UpFull, UpEmpty, CtlBusy   controller upload FIFO and busy status
//   UpByte, VerifyByte         byte and commit strobe into the upload FIFO
//   SendData                   one-cycle start-transmission pulse
//   FrameDone                  one-cycle pulse once the controller has drained the frame
//   Overflow                   sticky: payload hit MaxPayload without InLast
module uart_tx_framer import uart_pkg::*; #(
   parameter int unsigned         DataBits   = 8,
   parameter int unsigned         MaxPayload = 16,
   parameter logic [DataBits-1:0] SofByte    = SOF_DEFAULT
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [DataBits-1:0] InByte,
   input  logic                InValid,
   input  logic                InLast,
   output logic                InReady,
   input  logic                Abort,
   input  logic                UpFull,
   input  logic                UpEmpty,
   input  logic                CtlBusy,
   output logic [DataBits-1:0] UpByte,
   output logic                VerifyByte,
   output logic                SendData,
   output logic                FrameDone,
   output logic                Overflow
);

   localparam int unsigned CntW = $clog2(MaxPayload + 1);

   framer_state_t       state_q, state_d;
   logic                phase_q, phase_d;   // 0: push cycle A (commit), 1: cycle B (strobe low)
   logic                seen_q, seen_d;     // drain condition already true on the previous cycle
   logic [DataBits-1:0] chk_q, chk_d;
   logic                in_ready_q, in_ready_d;
   logic [DataBits-1:0] up_byte_q, up_byte_d;
   logic                verify_q, verify_d;
   logic                send_q, send_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;

   logic                buf_wr, buf_clr, buf_rd_next;
   logic [DataBits-1:0] buf_rd_data;
   logic [CntW-1:0]     count, rd_idx;
   logic                accept;
   logic [DataBits-1:0] push_byte;

   uart_frame_buf #(
      .DataBits (DataBits),
      .Depth    (MaxPayload),
      .CntW     (CntW)
   ) u_buf (
      .clk_i     (Clk),
      .rst_ni    (Reset),
      .clr_i     (buf_clr),
      .wr_en_i   (buf_wr),
      .wr_data_i (InByte),
      .rd_next_i (buf_rd_next),
      .rd_data_o (buf_rd_data),
      .count_o   (count),
      .rd_idx_o  (rd_idx)
   );

   function automatic logic [DataBits-1:0] chk_fold(input logic [DataBits-1:0] c,
                                                    input logic [DataBits-1:0] b);
`ifdef UART_TX_FRAMER_CRC8_EN
      return DataBits'(crc8_step(byte_t'(b), byte_t'(c)));
`else
      return DataBits'(checksum_update(byte_t'(c), byte_t'(b)));
`endif
   endfunction

   function automatic logic [DataBits-1:0] chk_final(input logic [DataBits-1:0] c);
`ifdef UART_TX_FRAMER_CRC8_EN
      return c;
`else
      return '0 - c;   // makes LEN + payload + CHK sum to zero
`endif
   endfunction

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      seen_d      = seen_q;
      chk_d       = chk_q;
      in_ready_d  = 1'b0;
      up_byte_d   = up_byte_q;
      verify_d    = 1'b0;
      send_d      = 1'b0;
      done_d      = 1'b0;
      ovf_d       = ovf_q;
      buf_wr      = 1'b0;
      buf_clr     = 1'b0;
      buf_rd_next = 1'b0;
      accept      = InValid && in_ready_q && !Abort;
      push_byte   = '0;

      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (Abort) begin
               buf_clr = 1'b1;
               state_d = ST_IDLE;
            end else if (accept) begin
               buf_wr  = 1'b1;
               state_d = ST_COLLECT;
               if (InLast) begin
                  state_d = ST_PUSH_SOF;
               end else if (32'(count) + 32'd1 == MaxPayload) begin
                  ovf_d   = 1'b1;
                  state_d = ST_PUSH_SOF;
               end
            end
         end

         ST_PUSH_SOF, ST_PUSH_LEN, ST_PUSH_DATA, ST_PUSH_CHK: begin
            case (state_q)
               ST_PUSH_SOF:  push_byte = SofByte;
               ST_PUSH_LEN:  push_byte = DataBits'(count);
               ST_PUSH_DATA: push_byte = buf_rd_data;
               default:      push_byte = chk_final(chk_q);
            endcase

            if (!phase_q) begin
               // A full FIFO simply holds us in cycle A until there is room.
               if (!UpFull) begin
                  up_byte_d = push_byte;
                  verify_d  = 1'b1;
                  phase_d   = 1'b1;
                  if (state_q == ST_PUSH_SOF) begin
                     chk_d = '0;
                  end else if (state_q == ST_PUSH_LEN || state_q == ST_PUSH_DATA) begin
                     chk_d = chk_fold(chk_q, push_byte);
                  end
               end
            end else begin
               phase_d = 1'b0;
               case (state_q)
                  ST_PUSH_SOF: state_d = ST_PUSH_LEN;
                  ST_PUSH_LEN: state_d = ST_PUSH_DATA;
                  ST_PUSH_DATA: begin
                     if (32'(rd_idx) + 32'd1 == 32'(count)) state_d = ST_PUSH_CHK;
                     else                                   buf_rd_next = 1'b1;
                  end
                  default: state_d = ST_KICK;
               endcase
            end
         end

         ST_KICK: begin
            send_d  = 1'b1;
            seen_d  = 1'b0;
            state_d = ST_DRAIN;
         end

         ST_DRAIN: begin
            if (UpEmpty && !CtlBusy) begin
               if (seen_q) begin
                  done_d  = 1'b1;
                  buf_clr = 1'b1;
                  seen_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  seen_d = 1'b1;
               end
            end else begin
               seen_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ST_IDLE;
         phase_q    <= 1'b0;
         seen_q     <= 1'b0;
         chk_q      <= '0;
         in_ready_q <= 1'b0;
         up_byte_q  <= '0;
         verify_q   <= 1'b0;
         send_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         seen_q     <= seen_d;
         chk_q      <= chk_d;
         in_ready_q <= in_ready_d;
         up_byte_q  <= up_byte_d;
         verify_q   <= verify_d;
         send_q     <= send_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign InReady    = in_ready_q;
   assign UpByte     = up_byte_q;
   assign VerifyByte = verify_q;
   assign SendData   = send_q;
   assign FrameDone  = done_q;
   assign Overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

   typedef logic [7:0] byte_q_t[$];

   logic       Clk, Reset;
   logic [7:0] InByte;
   logic       InValid, InLast, InReady, Abort;
   logic       UpFull, UpEmpty, CtlBusy;
   logic [7:0] UpByte;
   logic       VerifyByte, SendData, FrameDone, Overflow;

   int      vectors = 0;
   int      miscompares = 0;
   byte_q_t cap;
   byte_q_t pay;
   logic    vb_prev = 1'b0;
   int      send_cnt = 0;
   int      done_cnt = 0;

   uart_tx_framer dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .InByte     (InByte),
      .InValid    (InValid),
      .InLast     (InLast),
      .InReady    (InReady),
      .Abort      (Abort),
      .UpFull     (UpFull),
      .UpEmpty    (UpEmpty),
      .CtlBusy    (CtlBusy),
      .UpByte     (UpByte),
      .VerifyByte (VerifyByte),
      .SendData   (SendData),
      .FrameDone  (FrameDone),
      .Overflow   (Overflow)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Values read here are the ones held during the cycle that just ended.
   always @(posedge Clk) begin
      if (VerifyByte && !vb_prev) cap.push_back(UpByte);
      vb_prev = VerifyByte;
      if (SendData)  send_cnt++;
      if (FrameDone) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_chk(input byte_q_t b);
`ifdef UART_TX_FRAMER_CRC8_EN
      logic [7:0] r;
      logic       fb;
      r = 8'h00;
      foreach (b[i]) begin
         for (int k = 7; k >= 0; k--) begin
            fb = r[7] ^ b[i][k];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return r;
`else
      int s;
      s = 0;
      foreach (b[i]) s += int'(b[i]);
      return 8'((256 - (s % 256)) % 256);
`endif
   endfunction

   task automatic put(input logic [7:0] b, input logic last);
      int n;
      n = 0;
      @(negedge Clk);
      while (!InReady && n < 100) begin
         @(negedge Clk);
         n++;
      end
      chk("put_ready", {31'd0, InReady}, 32'd1);
      InByte  = b;
      InValid = 1'b1;
      InLast  = last;
      @(negedge Clk);
      InValid = 1'b0;
      InLast  = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      int start;
      n     = 0;
      start = done_cnt;
      while (done_cnt == start && n < 300) begin
         @(negedge Clk);
         n++;
      end
      chk("frame_done", done_cnt, start + 1);
   endtask

   task automatic check_frame(input string tag, input byte_q_t p);
      byte_q_t e;
      byte_q_t summed;
      e.push_back(8'h7E);
      e.push_back(8'(p.size()));
      summed.push_back(8'(p.size()));
      foreach (p[i]) begin
         e.push_back(p[i]);
         summed.push_back(p[i]);
      end
      e.push_back(exp_chk(summed));
      chk({tag, "_len"}, cap.size(), e.size());
      foreach (e[i]) begin
         chk($sformatf("%s_b%0d", tag, i), (i < cap.size()) ? {24'd0, cap[i]} : 32'hFFFF_FFFF, {24'd0, e[i]});
      end
   endtask

   initial begin
      int n;
      int s0;
      int d0;
      Reset = 1'b0; InByte = 8'h00; InValid = 1'b0; InLast = 1'b0; Abort = 1'b0;
      UpFull = 1'b0; UpEmpty = 1'b0; CtlBusy = 1'b1;

      // reset state
      repeat (3) @(negedge Clk);
      chk("rst_inready", {31'd0, InReady}, 32'd0);
      chk("rst_upbyte", {24'd0, UpByte}, 32'd0);
      chk("rst_verify", {31'd0, VerifyByte}, 32'd0);
      chk("rst_send", {31'd0, SendData}, 32'd0);
      chk("rst_done", {31'd0, FrameDone}, 32'd0);
      chk("rst_ovf", {31'd0, Overflow}, 32'd0);
      Reset = 1'b1;
      @(negedge Clk);
      chk("rel_inready", {31'd0, InReady}, 32'd1);

      // frame 01,02,03 with controller still busy; latency 2*(3+3)+1
      cap.delete();
      put(8'h01, 1'b0);
      put(8'h02, 1'b0);
      put(8'h03, 1'b1);
      n = 0;
      while (!SendData && n < 100) begin
         @(negedge Clk);
         n++;
      end
      chk("latency", n, 13);
      pay = {8'h01, 8'h02, 8'h03};
      check_frame("f123", pay);
      @(negedge Clk);
      chk("send_one_cycle", {31'd0, SendData}, 32'd0);
      repeat (4) @(negedge Clk);
      chk("no_done_busy", done_cnt, 0);
      UpEmpty = 1'b1;
      CtlBusy = 1'b0;
      @(negedge Clk);
      chk("done_not_yet", {31'd0, FrameDone}, 32'd0);
      @(negedge Clk);
      chk("done_pulse", {31'd0, FrameDone}, 32'd1);
      @(negedge Clk);
      chk("done_one_cycle", {31'd0, FrameDone}, 32'd0);
      chk("idle_inready", {31'd0, InReady}, 32'd1);
      chk("send_count", send_cnt, 1);

      // stall on UpFull during the payload pushes
      cap.delete();
      put(8'h10, 1'b0);
      put(8'h20, 1'b0);
      put(8'h30, 1'b0);
      put(8'h40, 1'b1);
      n = 0;
      while (cap.size() < 3 && n < 100) begin
         @(negedge Clk);
         n++;
      end
      chk("stall_reach", cap.size(), 3);
      UpFull = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("stall_verify", {31'd0, VerifyByte}, 32'd0);
      end
      chk("stall_cap", cap.size(), 3);
      UpFull = 1'b0;
      wait_done();
      pay = {8'h10, 8'h20, 8'h30, 8'h40};
      check_frame("fstall", pay);

      // 16 bytes without InLast -> forced end of frame
      cap.delete();
      pay.delete();
      for (int i = 0; i < 16; i++) begin
         put(8'(i), 1'b0);
         pay.push_back(8'(i));
      end
      chk("ovf_set", {31'd0, Overflow}, 32'd1);
      chk("ovf_inready", {31'd0, InReady}, 32'd0);
      wait_done();
      check_frame("fovf", pay);

      // abort after two bytes, byte presented with Abort is dropped
      cap.delete();
      s0 = send_cnt;
      put(8'h11, 1'b0);
      put(8'h22, 1'b0);
      Abort = 1'b1; InByte = 8'h33; InValid = 1'b1; InLast = 1'b1;
      @(negedge Clk);
      Abort = 1'b0; InValid = 1'b0; InLast = 1'b0;
      repeat (10) @(negedge Clk);
      chk("abort_nopush", cap.size(), 0);
      chk("abort_nosend", send_cnt, s0);
      put(8'hAA, 1'b1);
      wait_done();
      pay = {8'hAA};
      check_frame("faa", pay);
      chk("ovf_sticky", {31'd0, Overflow}, 32'd1);

      // reset while LEN is being strobed
      cap.delete();
      put(8'h05, 1'b1);
      repeat (3) @(negedge Clk);
      chk("len_verify", {31'd0, VerifyByte}, 32'd1);
      chk("len_byte", {24'd0, UpByte}, 32'h01);
      Reset = 1'b0;
      #1;
      chk("arst_verify", {31'd0, VerifyByte}, 32'd0);
      chk("arst_upbyte", {24'd0, UpByte}, 32'd0);
      chk("arst_inready", {31'd0, InReady}, 32'd0);
      chk("arst_ovf", {31'd0, Overflow}, 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      s0 = send_cnt;
      d0 = done_cnt;
      @(negedge Clk);
      chk("arst_rel_inready", {31'd0, InReady}, 32'd1);
      repeat (30) @(negedge Clk);
      chk("arst_nosend", send_cnt, s0);
      chk("arst_nodone", done_cnt, d0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
